// File: rtl/expand_max_pool_stream_pkg.sv
// Shared definitions for the expand-to-max stage: pool modes, FSM states and a signed max.
package expand_max_pool_stream_pkg;

   localparam logic POOL_BYPASS = 1'b0;
   localparam logic POOL_2X2    = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } state_t;

   // Callers sign-extend each lane to 32 bits and truncate the result back.
   function automatic logic signed [31:0] lane_max(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_ram.sv
// Simple dual-port line store with a registered (1-cycle) read port.
module pool_line_ram #(
   parameter int unsigned WIDTH  = 48,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/expand_max_pool_stream.sv
// Expand output stream to squeeze FIFO: bypass or 2x2 stride-2 signed max pool with
// runtime dimension/channel config and a single-register valid/ready output stage.
module expand_max_pool_stream
   import expand_max_pool_stream_pkg::*;
#(
   parameter int unsigned DATA_W       = 12,
   parameter int unsigned LANES        = 4,
   parameter int unsigned MAX_DIM      = 64,
   parameter int unsigned MAX_CH_BEATS = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic                       pool_en_i,
   input  logic [$clog2(MAX_DIM)-1:0] layer_dim_i,
   input  logic [$clog2(MAX_CH_BEATS)-1:0] ch_beats_i,
   input  logic [LANES*DATA_W-1:0]    in_data_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   output logic [LANES*DATA_W-1:0]    out_data_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int unsigned DIM_W  = $clog2(MAX_DIM);
   localparam int unsigned CB_W   = $clog2(MAX_CH_BEATS);
   localparam int unsigned BUS_W  = LANES * DATA_W;
   localparam int unsigned LINE_D = (MAX_DIM / 2) * MAX_CH_BEATS;
   localparam int unsigned LINE_A = $clog2(LINE_D);

   state_t            state_q, state_d;
   logic              pool_q;
   logic [DIM_W-1:0]  dim_q;
   logic [CB_W-1:0]   cb_q;
   logic [CB_W-1:0]   beat_q, beat_d;
   logic [DIM_W-1:0]  col_q, col_d, row_q, row_d;
   logic              out_valid_q;
   logic [BUS_W-1:0]  out_data_q;
   logic [BUS_W-1:0]  hold_q [MAX_CH_BEATS];

   logic              accept, last_beat, last_col, last_row, frame_last;
   logic              odd_row, odd_col, pooling, emit, hold_we, line_we;
   logic [BUS_W-1:0]  hold_rd, line_rd, pair_max, quad_max, result;
   logic [LINE_A-1:0] line_wr_addr, line_rd_addr;

   assign in_ready_o  = (state_q == StRun) & (~out_valid_q | out_ready_i);
   assign accept      = in_valid_i & in_ready_o;
   assign busy_o      = (state_q != StIdle);
   assign done_o      = (state_q == StDrain) & ~out_valid_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

   assign last_beat  = (beat_q == cb_q);
   assign last_col   = (col_q == dim_q);
   assign last_row   = (row_q == dim_q);
   assign frame_last = last_beat & last_col & last_row;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i) state_d = StRun;
         StRun:   if (accept && frame_last) state_d = StDrain;
         StDrain: if (!out_valid_q) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      beat_d = beat_q;
      col_d  = col_q;
      row_d  = row_q;
      if (accept) begin
         if (last_beat) begin
            beat_d = '0;
            if (last_col) begin
               col_d = '0;
               row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end else begin
            beat_d = beat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         pool_q  <= POOL_BYPASS;
         dim_q   <= '0;
         cb_q    <= '0;
         beat_q  <= '0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         col_q   <= col_d;
         row_q   <= row_d;
         if (state_q == StIdle && start_i) begin
            pool_q <= pool_en_i;
            dim_q  <= layer_dim_i;
            cb_q   <= ch_beats_i;
         end
      end
   end

   // The hold store carries the left pixel of every pair in both rows; the line store
   // only carries even-row pair maxima, so a line entry is never read in the cycle it
   // is written and the RAM needs no write-to-read bypass.
   assign odd_row = row_q[0];
   assign odd_col = col_q[0];
   assign pooling = (pool_q == POOL_2X2);
   assign hold_we = accept & pooling & ~odd_col;
   assign line_we = accept & pooling & ~odd_row & odd_col;
   assign emit    = (pool_q == POOL_BYPASS) | (odd_row & odd_col);
   assign hold_rd = hold_q[beat_q];

   always_ff @(posedge clk_i) begin
      if (hold_we) begin
         hold_q[beat_q] <= in_data_i;
      end
   end

   // Read address follows the next-beat counters so data is ready when that beat lands.
   assign line_wr_addr = {col_q[DIM_W-1:1], beat_q};
   assign line_rd_addr = {col_d[DIM_W-1:1], beat_d};

   pool_line_ram #(
      .WIDTH (BUS_W),
      .DEPTH (LINE_D),
      .ADDR_W(LINE_A)
   ) u_line_ram (
      .clk    (clk_i),
      .wr_en  (line_we),
      .wr_addr(line_wr_addr),
      .wr_data(pair_max),
      .rd_addr(line_rd_addr),
      .rd_data(line_rd)
   );

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [DATA_W-1:0] in_v, hold_v, line_v, pair_v, quad_v;
      assign in_v   = in_data_i[l*DATA_W +: DATA_W];
      assign hold_v = hold_rd[l*DATA_W +: DATA_W];
      assign line_v = line_rd[l*DATA_W +: DATA_W];
      assign pair_v = DATA_W'(lane_max(32'(in_v), 32'(hold_v)));
      assign quad_v = DATA_W'(lane_max(32'(pair_v), 32'(line_v)));
      assign pair_max[l*DATA_W +: DATA_W] = pair_v;
      assign quad_max[l*DATA_W +: DATA_W] = quad_v;
   end

   assign result = pooling ? quad_max : in_data_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (accept && emit) begin
         out_valid_q <= 1'b1;
         out_data_q  <= result;
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_expand_max_pool_stream.sv
// Randomised bench for expand_max_pool_stream against a 2x2 window-max reference model.
module tb_expand_max_pool_stream;

   localparam int DW    = 12;
   localparam int LN    = 4;
   localparam int MDIM  = 64;
   localparam int MCB   = 32;
   localparam int DIM_W = $clog2(MDIM);
   localparam int CB_W  = $clog2(MCB);
   localparam int BW    = DW * LN;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             pool_en;
   logic [DIM_W-1:0] layer_dim;
   logic [CB_W-1:0]  ch_beats;
   logic [BW-1:0]    in_data;
   logic             in_valid;
   logic             in_ready;
   logic [BW-1:0]    out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             done;

   expand_max_pool_stream #(
      .DATA_W      (DW),
      .LANES       (LN),
      .MAX_DIM     (MDIM),
      .MAX_CH_BEATS(MCB)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .pool_en_i  (pool_en),
      .layer_dim_i(layer_dim),
      .ch_beats_i (ch_beats),
      .in_data_i  (in_data),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .out_data_o (out_data),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .busy_o     (busy),
      .done_o     (done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [BW-1:0] fr[$];
   logic [BW-1:0] got[$];
   logic [BW-1:0] exp_q[$];
   int timed_out, done_cnt, done_cyc, last_hs_cyc, stall_err, ready_err;

   function automatic logic [DW-1:0] rnd_val(input int hi);
      int v;
      v = int'($urandom_range(hi + 2048)) - 2048;
      return v[DW-1:0];
   endfunction

   // Reference: beat order row, col, beat; pooled output is the per-lane max of each
   // complete 2x2 window, windows in raster order, beats innermost.
   task automatic build_expected(input bit pool, input int dim, input int cb);
      int n, nb, half, m, v;
      logic [BW-1:0] res, px;
      n = dim + 1;
      nb = cb + 1;
      half = n / 2;
      exp_q.delete();
      if (!pool) begin
         foreach (fr[i]) exp_q.push_back(fr[i]);
      end else begin
         for (int r = 0; r < half; r++)
            for (int c = 0; c < half; c++)
               for (int b = 0; b < nb; b++) begin
                  res = '0;
                  for (int l = 0; l < LN; l++) begin
                     m = -100000;
                     for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                           px = fr[((2*r+dy)*n + (2*c+dx))*nb + b];
                           v = $signed(px[l*DW +: DW]);
                           if (v > m) m = v;
                        end
                     res[l*DW +: DW] = m[DW-1:0];
                  end
                  exp_q.push_back(res);
               end
      end
   endtask

   task automatic run_frame(input bit pool, input int dim, input int cb, input int vpct,
                            input int rpct, input int abort_at);
      logic [BW-1:0] held;
      bit was_stalled, fin;
      int idx, cyc;
      got.delete();
      timed_out = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
      stall_err = 0; ready_err = 0;
      @(posedge clk); #1;
      start = 1'b1; pool_en = pool; layer_dim = dim[DIM_W-1:0]; ch_beats = cb[CB_W-1:0];
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      pool_en = ~pool;
      layer_dim = '1;
      idx = 0; cyc = 0; fin = 0; was_stalled = 0; held = '0;
      while (!fin) begin
         in_valid  = (idx < fr.size()) && ($urandom_range(99) < vpct);
         in_data   = (idx < fr.size()) ? fr[idx] : '0;
         out_ready = ($urandom_range(99) < rpct);
         @(negedge clk);
         if (was_stalled && (out_valid !== 1'b1 || out_data !== held)) stall_err++;
         if (out_valid && !out_ready && in_ready !== 1'b0) ready_err++;
         was_stalled = out_valid && !out_ready;
         held = out_data;
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            last_hs_cyc = cyc;
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         cyc++;
         if (done_cnt > 0 && cyc >= done_cyc + 3) fin = 1;
         if (abort_at > 0 && cyc >= abort_at) fin = 1;
         if (cyc >= 20000) begin
            timed_out = 1;
            fin = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic fill_random(input int dim, input int cb);
      fr.delete();
      for (int i = 0; i < (dim + 1) * (dim + 1) * (cb + 1); i++) begin
         logic [BW-1:0] w;
         for (int l = 0; l < LN; l++) w[l*DW +: DW] = rnd_val(2047);
         fr.push_back(w);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; pool_en = 1'b0; layer_dim = '0; ch_beats = '0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
      #23;
      vectors++;
      if ({out_valid, in_ready, busy, done} !== 4'b0 || out_data !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b r=%b b=%b d=%b data=%h, need all 0",
                  out_valid, in_ready, busy, done, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: got in_ready=%b busy=%b, need 0 0", in_ready, busy);
      end
   endtask

   task automatic check_frame(input string name, input bit pool, input int dim, input int cb);
      build_expected(pool, dim, cb);
      vectors++;
      if (timed_out != 0 || got.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL %s_count: got %0d beats (timeout=%0d), need %0d",
                  name, got.size(), timed_out, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         vectors++;
         if (got[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL %s_beat%0d: got %h, need %h", name, i, got[i], exp_q[i]);
         end
      end
      vectors++;
      if (done_cnt != 1) begin
         miscompares++;
         $display("FAIL %s_done_count: got %0d pulses, need 1", name, done_cnt);
      end
   endtask

   task automatic test_bypass;
      fr.delete();
      for (int p = 0; p < 16; p++)
         for (int b = 0; b < 2; b++) begin
            logic [BW-1:0] w;
            w = '0;
            w[0*DW +: DW] = DW'(p);
            w[1*DW +: DW] = DW'(b);
            w[2*DW +: DW] = rnd_val(2047);
            w[3*DW +: DW] = rnd_val(2047);
            fr.push_back(w);
         end
      run_frame(1'b0, 3, 1, 100, 100, 0);
      check_frame("bypass", 1'b0, 3, 1);
      vectors++;
      if (done_cyc != last_hs_cyc + 1) begin
         miscompares++;
         $display("FAIL bypass_done_timing: got done at %0d, need %0d", done_cyc,
                  last_hs_cyc + 1);
      end
   endtask

   task automatic test_pool_ramp;
      int need[4];
      logic [BW-1:0] w;
      need[0] = 5; need[1] = 7; need[2] = 13; need[3] = 15;
      fr.delete();
      for (int p = 0; p < 16; p++) begin
         w = '0;
         w[DW-1:0] = DW'(p);
         fr.push_back(w);
      end
      run_frame(1'b1, 3, 0, 100, 100, 0);
      vectors++;
      if (got.size() != 4) begin
         miscompares++;
         $display("FAIL ramp_count: got %0d, need 4", got.size());
      end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         vectors++;
         if (got[i] !== BW'(need[i])) begin
            miscompares++;
            $display("FAIL ramp_out%0d: got %h, need %0d", i, got[i], need[i]);
         end
      end
   endtask

   task automatic test_pool_negative;
      int win[4];
      logic [BW-1:0] w;
      logic [DW-1:0] lane;
      win[0] = -5; win[1] = -2; win[2] = -9; win[3] = -7;
      fr.delete();
      for (int p = 0; p < 4; p++) begin
         w = '0;
         for (int l = 0; l < LN; l++) w[l*DW +: DW] = DW'(win[(p + l) % 4]);
         fr.push_back(w);
      end
      run_frame(1'b1, 1, 0, 100, 100, 0);
      vectors++;
      if (got.size() != 1) begin
         miscompares++;
         $display("FAIL neg_count: got %0d, need 1", got.size());
      end else begin
         for (int l = 0; l < LN; l++) begin
            w = got[0];
            lane = w[l*DW +: DW];
            vectors++;
            if (lane !== 12'hFFE) begin
               miscompares++;
               $display("FAIL neg_lane%0d: got %h, need ffe", l, lane);
            end
         end
      end
   endtask

   task automatic test_pool_odd;
      int idx;
      fill_random(4, 1);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            if (r == 4 || c == 4)
               for (int b = 0; b < 2; b++) begin
                  idx = (r * 5 + c) * 2 + b;
                  for (int l = 0; l < LN; l++) fr[idx][l*DW +: DW] = 12'h7FF;
               end
      for (int i = 0; i < fr.size(); i++)
         for (int l = 0; l < LN; l++)
            if (fr[i][l*DW +: DW] == 12'h7FF && (i / 2) % 5 != 4 && (i / 10) != 4)
               fr[i][l*DW +: DW] = 12'h7FE;
      run_frame(1'b1, 4, 1, 100, 100, 0);
      check_frame("odd", 1'b1, 4, 1);
   endtask

   task automatic test_backpressure;
      bit pool;
      int dim, cb;
      for (int k = 0; k < 4; k++) begin
         pool = (k != 1);
         dim = int'($urandom_range(7, 1));
         cb = int'($urandom_range(3));
         fill_random(dim, cb);
         run_frame(pool, dim, cb, 70, 50, 0);
         check_frame("bp", pool, dim, cb);
         vectors++;
         if (stall_err != 0 || ready_err != 0) begin
            miscompares++;
            $display("FAIL bp_stall%0d: got %0d unstable and %0d ready errors, need 0 0",
                     k, stall_err, ready_err);
         end
      end
   endtask

   task automatic test_reset_midframe;
      fill_random(5, 1);
      run_frame(1'b1, 5, 1, 100, 100, 40);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_busy: got %b, need 1", busy);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({out_valid, in_ready, busy, done} !== 4'b0 || out_data !== '0) begin
         miscompares++;
         $display("FAIL mid_reset: got v=%b r=%b b=%b d=%b data=%h, need all 0",
                  out_valid, in_ready, busy, done, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      fill_random(3, 2);
      run_frame(1'b1, 3, 2, 90, 80, 0);
      check_frame("after_reset", 1'b1, 3, 2);
   endtask

   initial begin
      test_reset;
      test_bypass;
      test_pool_ramp;
      test_pool_negative;
      test_pool_odd;
      test_backpressure;
      test_reset_midframe;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/expand_max_pool_stream.md
Name: expand_max_pool_stream

Overview:
Parametrised successor of the expand-to-max stage in the fire pipeline. It accepts the concatenated expand output stream (LANES signed channels per beat, raster order, channel beats innermost) and either passes it through or applies a 2x2 stride-2 max pool. Results go to the squeeze input FIFO over a valid/ready handshake.
New relative to the previous generation: runtime dimension and channel config, true backpressure, odd-dimension handling and a frame-done pulse.

Parameters:
DATA_W, 12, bits per signed channel value
LANES, 4, channels per beat
MAX_DIM, 64, maximum layer width/height in pixels
MAX_CH_BEATS, 32, maximum channel beats per pixel (channels/LANES)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  pulse: latch config, begin frame (honoured only in IDLE)
pool_en_i  in  1  1 = 2x2/s2 max pool, 0 = bypass
layer_dim_i  in  clog2(MAX_DIM)  input width = height, minus 1
ch_beats_i  in  clog2(MAX_CH_BEATS)  beats per pixel, minus 1
in_data_i  in  LANES*DATA_W  lane 0 in LSBs
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when valid & ready
out_data_o  out  LANES*DATA_W  pooled/bypassed beat
out_valid_o  out  1  output beat valid
out_ready_i  in  1  downstream (squeeze FIFO not full)
busy_o  out  1  high from start to done
done_o  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, active-high, also mid-frame): state IDLE; all counters 0; out_valid_o=0; out_data_o=0; in_ready_o=0; busy_o=0; done_o=0. Any partial frame is abandoned. Line memory contents are don't-care.
- FSM IDLE -> RUN on start_i, latching pool_en, dim, ch_beats. RUN -> DRAIN when the last input beat is accepted. DRAIN -> IDLE when out_valid_o=0, pulsing done_o for that single cycle.
- start_i outside IDLE is ignored. in_ready_o is held 0 in IDLE and DRAIN.
- Counters: beat 0..ch_beats, then col 0..dim, then row 0..dim. All advance only on an accepted beat.
- Handshake: single output register. in_ready_o = RUN & (~out_valid_o | out_ready_i).
- Latency: output appears 1 cycle after acceptance. Full throughput of 1 beat/cycle when out_ready_i=1.
- out_data_o is held stable while out_valid_o & ~out_ready_i.
- Bypass: every accepted beat is forwarded unchanged.
- Pool, per lane, signed compare:
  - Even row, even col: write to hold store [beat].
  - Even row, odd col: max(in, hold[beat]) written to line store [col>>1][beat].
  - Odd row, even col: max(in, line[col>>1][beat]) written back to line store.
  - Odd row, odd col: out = max(in, hold[beat], line[col>>1][beat]); emitted.
  - The odd-row even-col hold update uses the line store so emission needs only one line read. The implementation may instead keep the hold store for this term.
- Odd dimension (dim+1 odd): the last column and the last row are consumed but produce nothing. Output is floor((dim+1)/2) square.
- Line store depth = (MAX_DIM/2)*MAX_CH_BEATS with 1-cycle read latency. The read address is precomputed from next-beat counters so there is no stall.
- Simultaneous out_ready_i and new acceptance: the register reloads in the same cycle with no bubble.
- Equal values: max returns either; the result is bit-identical.
- Values of dim or ch_beats beyond the parameters are out of contract.

Decomposition:
- Shared package: pool-mode constants (POOL_BYPASS=0, POOL_2X2=1), FSM state encoding (IDLE, RUN, DRAIN), and a lane-wise signed max function.
- One sub-module: pool_line_ram, a simple dual-port RAM (width LANES*DATA_W, depth (MAX_DIM/2)*MAX_CH_BEATS) with 1-cycle registered read.
- The hold store is a register array (MAX_CH_BEATS deep) inside the top.

Test Plan:
- Bypass, dim=3 (4x4), ch_beats=1, lane value = pixel index, out_ready=1 -> 32 output beats identical to input in order; done_o pulses once, one cycle after the last output handshake.
- Pool, dim=3, ch_beats=0, ramp 0..15 in lane 0 -> 4 outputs: 5, 7, 13, 15.
- Pool, negatives: window {-5,-2,-9,-7} -> -2, checked in all lanes independently.
- Pool, dim=4 (5x5, odd) -> exactly 4 outputs. Column 4 and row 4 are ignored, including a value of +2047 placed there.
- Backpressure: out_ready toggling 1/0 randomly -> in_ready_o low whenever the output is held. No loss or duplication; out_data stable while stalled.
- Reset asserted mid-frame, then a new start -> outputs return to reset values immediately. The second frame's results are correct and contain no residue from the first.
